regfile_read_mux: RTL
=====================

REGFILE_READ_MUX -- requirements
Module: regfile_read_mux

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register and port, in bits.
REQ-002 Parameter DEPTH, default 16: number of registers; power of two, 2..256.
REQ-003 Parameter AW, default 4: address width; SHALL equal log2(DEPTH).
REQ-004 Parameter ZERO_R0, default 0: when 1, register 0 SHALL read as zero and ignore writes.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write strobe.
REQ-008 wr_addr  in  AW  write register index.
REQ-009 wr_data  in  WIDTH  write data.
REQ-010 rd_en  in  1  read request; captures both read addresses.
REQ-011 rd_addr_a  in  AW  port A register index.
REQ-012 rd_addr_b  in  AW  port B register index.
REQ-013 rd_data_a  out  WIDTH  registered port A data.
REQ-014 rd_data_b  out  WIDTH  registered port B data.
REQ-015 rd_valid  out  1  high for exactly one cycle when rd_data_a and rd_data_b carry a new result.

Function
REQ-016 Storage SHALL be DEPTH registers of WIDTH bits, written on a rising edge with wr_en=1 at wr_addr.
REQ-017 Read latency SHALL be 1 cycle: rd_en=1 at edge N gives rd_data_* and rd_valid=1 after edge N.
REQ-018 rd_data_* SHALL hold their last value while rd_en=0; rd_valid SHALL drop to 0 after the next edge with rd_en=0.
REQ-019 Read SHALL be a DEPTH-to-1 selection per port; ports A and B SHALL be independent and may address the same register.
REQ-020 Write/read same edge, same address: captured read data SHALL be the new wr_data (write-through bypass), per port independently.
REQ-021 Write/read same edge, different address: read SHALL return the pre-write contents.
REQ-022 ZERO_R0=1: a write to address 0 SHALL be discarded; a read of address 0 SHALL return 0, including in the bypass case of REQ-020.
REQ-023 ZERO_R0=0: register 0 SHALL behave like every other register.
REQ-024 Back-to-back rd_en SHALL be accepted every cycle; rd_valid SHALL then remain high continuously.
REQ-025 Addresses are full-range by construction (DEPTH = 2^AW); no out-of-range handling.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 reset=1 at a rising edge SHALL clear all DEPTH registers, rd_data_a, rd_data_b and rd_valid to 0.
REQ-028 reset SHALL override wr_en and rd_en on the same edge; neither the write nor the read takes effect.
REQ-029 Reset asserted mid-stream (rd_valid=1) SHALL force rd_valid=0 after that edge; the first read after reset SHALL return 0 for any unwritten register.

Verification
REQ-030 Reset, then rd_en=1, rd_addr_a=3, rd_addr_b=15 -> after 1 edge rd_data_a=0, rd_data_b=0, rd_valid=1.
REQ-031 Write 0x1234 to R5, then 0xBEEF to R9, then read A=5, B=9 -> rd_data_a=0x1234, rd_data_b=0xBEEF one edge after rd_en.
REQ-032 Same edge: wr_en=1, wr_addr=7, wr_data=0xA5A5; rd_en=1, rd_addr_a=7, rd_addr_b=6 (R6=0x0006) -> rd_data_a=0xA5A5, rd_data_b=0x0006.
REQ-033 ZERO_R0=1: write 0xFFFF to R0 with a same-edge read of A=0, then read A=0 again -> rd_data_a=0 both times; same sequence with ZERO_R0=0 -> 0xFFFF both times.
REQ-034 Fill all 16 registers with 0x0100+i, then read (i, 15-i) on consecutive cycles for i=0..15 -> rd_valid high for 16 cycles, data matches, rd_valid low on the cycle after the last read; then assert reset -> all reads return 0.
REQ-035 Re-run REQ-030..REQ-034 with WIDTH=32, DEPTH=8, AW=3, addresses taken modulo 8 and 32-bit data -> identical behaviour.

Source files
------------

// File: rtl/regfile_read_mux.sv
// Register file: one write port and two independently addressed read ports.
// Reads are registered with a single cycle of latency and write-through bypass.
module regfile_read_mux #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int ZERO_R0 = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] data_a_p1;
   logic [WIDTH-1:0] data_b_p1;
   logic             vld_p1;
   logic             wr_allowed;

   // Register 0 is hardwired to zero when ZERO_R0 is set.
   function automatic logic [WIDTH-1:0] sel_port(
      input logic [AW-1:0]    addr,
      input logic [WIDTH-1:0] stored,
      input logic             wr_hit,
      input logic [WIDTH-1:0] wdata
   );
      if (ZERO_R0 != 0 && addr == '0) return '0;
      if (wr_hit) return wdata;
      return stored;
   endfunction

   assign wr_allowed = wr_en && !(ZERO_R0 != 0 && wr_addr == '0);

   // Stage p1: storage update and captured read results
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         data_a_p1 <= '0;
         data_b_p1 <= '0;
         vld_p1    <= 1'b0;
      end else begin
         if (wr_allowed) mem[wr_addr] <= wr_data;
         if (rd_en) begin
            data_a_p1 <= sel_port(rd_addr_a, mem[rd_addr_a],
                                  wr_en && (wr_addr == rd_addr_a), wr_data);
            data_b_p1 <= sel_port(rd_addr_b, mem[rd_addr_b],
                                  wr_en && (wr_addr == rd_addr_b), wr_data);
         end
         vld_p1 <= rd_en;
      end
   end

   assign rd_data_a = data_a_p1;
   assign rd_data_b = data_b_p1;
   assign rd_valid  = vld_p1;

endmodule
